// File: rtl/aes_host_seq.sv
// aes_host_seq: byte-stream front end for aes_core fault-injection runs.
// Collects a 49-byte command frame (header, 32 key bytes, 16 data bytes),
// fires one load pulse, times the core's busy and glitch-window phases,
// then streams back a 20-byte response (status, result, cyc_cnt, en_cnt).
module aes_host_seq #(
  parameter int TIMEOUT = 1023
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   rx_data_i,
  input  logic         rx_valid_i,
  output logic         rx_ready_o,
  output logic [7:0]   tx_data_o,
  output logic         tx_valid_o,
  input  logic         tx_ready_i,
  output logic         core_load_o,
  output logic [255:0] core_key_o,
  output logic [127:0] core_data_o,
  output logic [1:0]   core_size_o,
  output logic         core_dec_o,
  input  logic [127:0] core_data_i,
  input  logic         core_busy_i,
  input  logic         core_enable_i,
  output logic         idle_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_KEY,
    S_DATA,
    S_LOAD,
    S_WAIT,
    S_TX
  } state_t;

  localparam logic [15:0] TMO = 16'(TIMEOUT);

  state_t         state, state_nxt;
  logic [5:0]     idx;       // byte index within KEY / DATA / TX
  logic [127:0]   result;
  logic [7:0]     status;
  logic [15:0]    cyc_cnt;
  logic [7:0]     en_cnt;

  logic           rx_fire, tx_fire;
  logic [15:0]    cyc_inc;
  logic           timeout_hit;
  logic [5:0]     res_idx;
  logic           unused_hdr;

  // Header bits 6 and 3:0 carry no meaning.
  assign unused_hdr = ^{rx_data_i[6], rx_data_i[3:0]};

  assign rx_fire = rx_valid_i && rx_ready_o;
  assign tx_fire = tx_valid_o && tx_ready_i;

  // Busy-cycle counter value for this cycle, saturating at all-ones.
  assign cyc_inc     = (cyc_cnt == 16'hFFFF) ? cyc_cnt : cyc_cnt + 16'd1;
  assign timeout_hit = core_busy_i && (cyc_inc >= TMO);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (rx_fire) state_nxt = S_KEY;
      S_KEY:  if (rx_fire && idx == 6'd31) state_nxt = S_DATA;
      S_DATA: if (rx_fire && idx == 6'd15) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_WAIT;
      S_WAIT: if (!core_busy_i || timeout_hit) state_nxt = S_TX;
      S_TX:   if (tx_fire && idx == 6'd19) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output decode; tx_data_o depends only on idx and response registers,
  // so it cannot move while a byte is stalled.
  always_comb begin
    rx_ready_o  = (state == S_IDLE) || (state == S_KEY) || (state == S_DATA);
    tx_valid_o  = (state == S_TX);
    core_load_o = (state == S_LOAD);
    idle_o      = (state == S_IDLE);
    res_idx     = idx - 6'd1;
    tx_data_o   = 8'h00;
    if (state == S_TX) begin
      case (idx)
        6'd0:    tx_data_o = status;
        6'd17:   tx_data_o = cyc_cnt[15:8];
        6'd18:   tx_data_o = cyc_cnt[7:0];
        6'd19:   tx_data_o = en_cnt;
        default: tx_data_o = result[{~res_idx[3:0], 3'b000} +: 8];
      endcase
    end
  end

  // Frame capture, core operand registers, counters and response datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx         <= '0;
      core_key_o  <= '0;
      core_data_o <= '0;
      core_size_o <= '0;
      core_dec_o  <= 1'b0;
      result      <= '0;
      status      <= '0;
      cyc_cnt     <= '0;
      en_cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rx_fire) begin
            core_dec_o  <= rx_data_i[7];
            core_size_o <= rx_data_i[5:4];
            idx         <= '0;
          end
        end
        S_KEY: begin
          // Byte 0 of the key lands in the top byte.
          if (rx_fire) begin
            core_key_o[{~idx[4:0], 3'b000} +: 8] <= rx_data_i;
            idx <= (idx == 6'd31) ? 6'd0 : idx + 6'd1;
          end
        end
        S_DATA: begin
          if (rx_fire) begin
            core_data_o[{~idx[3:0], 3'b000} +: 8] <= rx_data_i;
            idx <= (idx == 6'd15) ? 6'd0 : idx + 6'd1;
          end
        end
        S_LOAD: begin
          cyc_cnt <= '0;
          en_cnt  <= '0;
          idx     <= '0;
        end
        S_WAIT: begin
          // Glitch-window cycles are counted in every WAIT cycle,
          // including the completing one.
          if (core_enable_i && en_cnt != 8'hFF) en_cnt <= en_cnt + 8'd1;
          if (!core_busy_i) begin
            result <= core_data_i;
            status <= 8'h00;
          end else begin
            cyc_cnt <= cyc_inc;
            if (timeout_hit) begin
              result <= '0;
              status <= 8'h01;
            end
          end
        end
        S_TX: begin
          if (tx_fire) idx <= (idx == 6'd19) ? 6'd0 : idx + 6'd1;
        end
        default: idx <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_host_seq.sv
// Bench for aes_host_seq: stub aes_core, scoreboard of expected response
// bytes, and one task per scenario.
module tb_aes_host_seq;

  localparam logic [255:0] FKEY = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam int BOUND = 2000;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [7:0]   rx_data;
  logic         rx_valid;
  logic         rx_ready;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         core_load;
  logic [255:0] core_key;
  logic [127:0] core_data;
  logic [1:0]   core_size;
  logic         core_dec;
  logic [127:0] core_res;
  logic         core_busy;
  logic         core_enable;
  logic         idle;

  int tests = 0;
  int fails = 0;
  int ld_cnt = 0;
  logic [255:0] ld_key;
  logic [1:0]   ld_size;
  logic [7:0]   sb[$];
  bit           hang = 1'b0;

  always #5 clk = ~clk;

  aes_host_seq #(.TIMEOUT(20)) dut (
    .clk(clk), .rst_n(rst_n),
    .rx_data_i(rx_data), .rx_valid_i(rx_valid), .rx_ready_o(rx_ready),
    .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
    .core_load_o(core_load), .core_key_o(core_key), .core_data_o(core_data),
    .core_size_o(core_size), .core_dec_o(core_dec),
    .core_data_i(core_res), .core_busy_i(core_busy),
    .core_enable_i(core_enable), .idle_o(idle)
  );

  // Stub core: knows the FIPS-197 pair, otherwise XORs data with key top half.
  function automatic logic [127:0] stub_fn(input logic dec, input logic [255:0] k,
                                           input logic [127:0] d);
    if (!dec && k == FKEY && d == PT) return CT;
    if (dec && k == FKEY && d == CT)  return PT;
    return d ^ k[255:128];
  endfunction

  // Stub core: busy for 11 cycles after load (forever when hang), glitch
  // window on busy cycles 7 and 8.
  logic [7:0] stub_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      core_busy <= 1'b0;
      stub_cnt  <= '0;
      core_res  <= '0;
    end else if (core_load) begin
      core_busy <= 1'b1;
      stub_cnt  <= '0;
      core_res  <= stub_fn(core_dec, core_key, core_data);
    end else if (core_busy) begin
      if (stub_cnt != 8'hFF) stub_cnt <= stub_cnt + 8'd1;
      if (stub_cnt == 8'd10 && !hang) core_busy <= 1'b0;
    end
  end
  assign core_enable = core_busy && (stub_cnt == 8'd7 || stub_cnt == 8'd8);

  task automatic push_resp(input logic [7:0] st, input logic [127:0] res,
                           input logic [15:0] cyc, input logic [7:0] en);
    sb.push_back(st);
    for (int i = 0; i < 16; i++) sb.push_back(res[8*(15-i) +: 8]);
    sb.push_back(cyc[15:8]);
    sb.push_back(cyc[7:0]);
    sb.push_back(en);
  endtask

  // Monitor: scoreboard pop on each TX handshake, hold check while stalled,
  // rx_ready low from load through TX.
  task automatic monitor();
    logic [7:0] prev_data = '0;
    bit prev_stall = 1'b0;
    bit waiting = 1'b0;
    logic [7:0] exp;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
        waiting = 1'b0;
      end else begin
        if (core_load) begin
          ld_cnt++;
          ld_key = core_key;
          ld_size = core_size;
          waiting = 1'b1;
        end
        if (tx_valid) waiting = 1'b0;
        if (core_load || waiting || tx_valid) begin
          tests++;
          if (rx_ready !== 1'b0) begin
            fails++;
            $display("FAIL rx_ready_busy: got %b want 0 at %0t", rx_ready, $time);
          end
        end
        if (prev_stall) begin
          tests++;
          if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
            fails++;
            $display("FAIL tx_hold: got v=%b d=%h want v=1 d=%h", tx_valid, tx_data, prev_data);
          end
        end
        if (tx_valid && tx_ready) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL tx_extra: got %h with empty scoreboard", tx_data);
          end else begin
            exp = sb.pop_front();
            if (tx_data !== exp) begin
              fails++;
              $display("FAIL tx_byte: got %h want %h at %0t", tx_data, exp, $time);
            end
          end
        end
        prev_stall = tx_valid && !tx_ready;
        prev_data = tx_data;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    bit acc;
    if (gap) begin
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end
    rx_data = b;
    rx_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < BOUND) begin
      @(negedge clk);
      acc = rx_ready;
      @(posedge clk); #1;
      n++;
    end
    rx_valid = 1'b0;
    tests++;
    if (!acc) begin
      fails++;
      $display("FAIL rx_accept: byte %h not taken within %0d cycles", b, BOUND);
    end
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [255:0] key,
                            input logic [127:0] data, input bit gap, input int nbytes);
    logic [7:0] b;
    for (int i = 0; i < nbytes; i++) begin
      if (i == 0)       b = hdr;
      else if (i <= 32) b = key[8*(32-i) +: 8];
      else              b = data[8*(48-i) +: 8];
      send_byte(b, gap);
    end
    if (nbytes == 49) begin
      tests++;
      if (core_load !== 1'b1) begin
        fails++;
        $display("FAIL load_latency: core_load %b want 1 after last byte", core_load);
      end
    end
  endtask

  task automatic wait_resp();
    int n = 0;
    while ((sb.size() != 0 || !idle) && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= BOUND) begin
      fails++;
      $display("FAIL resp_timeout: %0d bytes outstanding, idle %b", sb.size(), idle);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_data = '0;
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (idle !== 1'b1 || rx_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_idle: idle %b rx_ready %b want 1 1", idle, rx_ready);
    end
    tests++;
    if (tx_valid !== 1'b0 || core_load !== 1'b0 || tx_data !== 8'h00) begin
      fails++;
      $display("FAIL reset_ctrl: tx_valid %b load %b tx_data %h want 0 0 00", tx_valid, core_load, tx_data);
    end
    tests++;
    if (core_key !== '0 || core_data !== '0 || core_size !== 2'd0 || core_dec !== 1'b0) begin
      fails++;
      $display("FAIL reset_core: key %h data %h size %0d dec %b want 0", core_key, core_data, core_size, core_dec);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fips();
    int l0 = ld_cnt;
    int n = 0;
    push_resp(8'h00, CT, 16'd11, 8'd2);
    send_frame(8'h00, FKEY, PT, 1'b0, 49);
    while (!tx_valid && n < BOUND) begin @(negedge clk); n++; end
    n = 0;
    while (!idle && n < BOUND) begin @(negedge clk); n++; end
    tests++;
    if (n != 20) begin
      fails++;
      $display("FAIL tx_cycles: got %0d want 20", n);
    end
    wait_resp();
    tests++;
    if (ld_cnt != l0 + 1) begin
      fails++;
      $display("FAIL fips_loads: got %0d want 1", ld_cnt - l0);
    end
    tests++;
    if (core_data !== PT || core_key !== FKEY) begin
      fails++;
      $display("FAIL operand_hold: data %h want %h", core_data, PT);
    end
  endtask

  task automatic test_decrypt();
    push_resp(8'h00, PT, 16'd11, 8'd2);
    send_frame(8'h80, FKEY, CT, 1'b0, 49);
    wait_resp();
    tests++;
    if (core_dec !== 1'b1) begin
      fails++;
      $display("FAIL dec_flag: got %b want 1", core_dec);
    end
  endtask

  task automatic test_backpressure();
    bit done = 1'b0;
    push_resp(8'h00, CT, 16'd11, 8'd2);
    fork
      begin
        send_frame(8'h00, FKEY, PT, 1'b1, 49);
        wait_resp();
        done = 1'b1;
      end
      begin
        int n = 0;
        while (!done && n < 5000) begin
          @(posedge clk); #1;
          tx_ready = 1'($urandom_range(0, 1));
          n++;
        end
      end
    join
    tx_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    hang = 1'b1;
    push_resp(8'h01, 128'h0, 16'h0014, 8'd2);
    send_frame(8'h00, FKEY, PT, 1'b0, 49);
    wait_resp();
    hang = 1'b0;
  endtask

  task automatic test_reset_mid();
    int l0;
    logic [255:0] key = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
    logic [127:0] data = {$urandom, $urandom, $urandom, $urandom};
    send_frame(8'h10, FKEY, PT, 1'b0, 40);
    l0 = ld_cnt;
    rst_n = 1'b0;
    #1;
    tests++;
    if (idle !== 1'b1 || core_load !== 1'b0 || tx_valid !== 1'b0 || core_key !== '0) begin
      fails++;
      $display("FAIL reset_mid: idle %b load %b tx_valid %b key %h", idle, core_load, tx_valid, core_key);
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    push_resp(8'h00, data ^ key[255:128], 16'd11, 8'd2);
    send_frame(8'h10, key, data, 1'b0, 49);
    wait_resp();
    tests++;
    if (ld_cnt != l0 + 1) begin
      fails++;
      $display("FAIL abort_load: got %0d loads want 1", ld_cnt - l0);
    end
  endtask

  task automatic test_passthrough();
    logic [255:0] key;
    logic [127:0] data = 128'hcafebabe_deadbeef_01234567_89abcdef;
    for (int i = 1; i <= 32; i++) key[8*(32-i) +: 8] = 8'(i);
    push_resp(8'h00, data ^ key[255:128], 16'd11, 8'd2);
    send_frame(8'h20, key, data, 1'b0, 49);
    wait_resp();
    tests++;
    if (ld_size !== 2'd2) begin
      fails++;
      $display("FAIL size_pass: got %0d want 2", ld_size);
    end
    tests++;
    if (ld_key !== 256'h0102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f20) begin
      fails++;
      $display("FAIL key_pass: got %h", ld_key);
    end
  endtask

  task automatic test_back_to_back();
    int l0 = ld_cnt;
    logic [127:0] d2 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    push_resp(8'h00, CT, 16'd11, 8'd2);
    push_resp(8'h00, d2 ^ FKEY[255:128], 16'd11, 8'd2);
    send_frame(8'h00, FKEY, PT, 1'b0, 49);
    // Second header is presented while the first frame is still busy.
    send_frame(8'h4F, FKEY, d2, 1'b0, 49);
    tests++;
    if (ld_size !== 2'd0) begin
      fails++;
      $display("FAIL hdr_ignore: size %0d want 0", ld_size);
    end
    wait_resp();
    tests++;
    if (ld_cnt != l0 + 2 || core_dec !== 1'b0) begin
      fails++;
      $display("FAIL b2b_loads: got %0d dec %b want 2 0", ld_cnt - l0, core_dec);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_fips();
    test_decrypt();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_passthrough();
    test_back_to_back();
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_leftover: %0d bytes never sent", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/aes_host_seq.md
# aes_host_seq

Byte-stream sequencer that drives the `aes_core` encrypt/decrypt interface for fault-injection campaigns. It assembles a command frame from an 8-bit valid/ready input stream, issues a single load pulse, waits for the core to finish, and returns a 20-byte response. The response carries the result block, the busy-cycle count and the number of cycles the core's glitch-window enable was high. It sits between the host link (UART/USB bridge) and `aes_core`.

## Interface
- `TIMEOUT`, default 1023: maximum number of busy cycles before the operation is abandoned.
- `clk`  in  1  system clock; every register is clocked on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx_data_i`  in  8  command stream byte.
- `rx_valid_i`  in  1  `rx_data_i` is valid.
- `rx_ready_o`  out  1  a byte is accepted in each cycle where `rx_valid_i && rx_ready_o`.
- `tx_data_o`  out  8  response byte.
- `tx_valid_o`  out  1  `tx_data_o` is valid.
- `tx_ready_i`  in  1  a byte is consumed in each cycle where `tx_valid_o && tx_ready_i`.
- `core_load_o`  out  1  one-cycle load pulse to the core.
- `core_key_o`  out  256  key to the core.
- `core_data_o`  out  128  input block to the core.
- `core_size_o`  out  2  key size: 0 = AES-128, 1 = AES-192, 2 = AES-256.
- `core_dec_o`  out  1  1 = decrypt.
- `core_data_i`  in  128  result block from the core.
- `core_busy_i`  in  1  core busy flag.
- `core_enable_i`  in  1  glitch-window enable from the core.
- `idle_o`  out  1  high when in IDLE.

## Operation
**Frame format (49 bytes, MSB first):**
- Byte 0 is the header: bit 7 = dec, bits 5:4 = size, bits 6 and 3:0 are ignored.
- Bytes 1–32 are the key; byte 1 lands in `core_key_o[255:248]`. AES-128 keys occupy `[255:128]` and AES-192 keys occupy `[255:64]`; the host pads the unused bytes with zeros. Size 3 is passed through unchanged.
- Bytes 33–48 are the data block; byte 33 lands in `core_data_o[127:120]`.

**States:**
- IDLE: accept the header, latch dec and size, go to KEY.
- KEY: accept 32 bytes using a 6-bit byte index, then go to DATA.
- DATA: accept 16 bytes, then go to LOAD.
- LOAD: assert `core_load_o` for exactly one cycle, clear both counters, go to WAIT.
- WAIT: once per cycle:
  - If `core_busy_i` = 0, capture `core_data_i` into the result register, set status 0x00, go to TX.
  - Otherwise increment `cyc_cnt` (16-bit, saturates at 0xFFFF).
  - If `core_enable_i` = 1, increment `en_cnt` (8-bit, saturates at 0xFF). This applies in every WAIT cycle.
  - If `cyc_cnt` reaches `TIMEOUT`, zero the result register, set status 0x01, go to TX.
- TX: send 20 bytes in this order: status, result[127:120] … result[7:0], `cyc_cnt[15:8]`, `cyc_cnt[7:0]`, `en_cnt`. Return to IDLE after the last handshake.

**Rules:**
- `rx_ready_o` = 1 only in IDLE, KEY and DATA.
- In all other states, input bytes are not consumed; the host must hold them.
- `core_key_o`, `core_data_o`, `core_size_o` and `core_dec_o` hold their last values until the next frame overwrites them.
- `tx_valid_o` = 1 throughout TX. `tx_data_o` must not change while `tx_valid_o && !tx_ready_i`.
- `core_busy_i` is ignored outside WAIT.
- `core_enable_i` is counted only in WAIT, so any stale core round value before the load is never counted.

## Timing
**Reset values:** state IDLE, so `idle_o` = 1 and `rx_ready_o` = 1 (decoded from state, also during reset). All other outputs, counters and the byte index are 0.

**Input side:** byte-accept to state advance is one cycle. The last data byte, accepted in cycle t, puts the block in LOAD at t+1; `core_load_o` is high only in cycle t+1.

**WAIT:** starts at t+2, where the core's `busy_o` is already 1.
- Completion is the first WAIT cycle with busy = 0; `core_data_i` is sampled in that same cycle.
- AES-128 encryption gives `cyc_cnt` = 11. Per the core's current glitch window (rounds 7–8), it also gives `en_cnt` = 2.

**TX:** the first byte is valid the cycle after completion. With `tx_ready_i` held at 1, the 20 bytes take 20 consecutive cycles and IDLE is re-entered the following cycle.

**Reset mid-operation:** asynchronously returns to IDLE, drops `core_load_o` and `tx_valid_o`, and discards any partial frame or response. A partially received frame is never loaded.

**Back-to-back frames:** no idle cycle is required between the last TX handshake and the next header byte.

## Test plan
- FIPS-197 check, `tx_ready_i` = 1:
  - Stimulus: header 0x00; key 000102…0f followed by 16 zero bytes; data 00112233445566778899aabbccddeeff.
  - Response: one load pulse, then 00 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a 00 0b 02.
- Decrypt:
  - Stimulus: header 0x80, same key, data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Response: status 00 and result 00112233…eeff.
- Backpressure: repeat the FIPS-197 check with `tx_ready_i` toggled randomly and `rx_valid_i` gapped -> identical byte sequence, `tx_data_o` stable while stalled, `rx_ready_o` = 0 in LOAD, WAIT and TX.
- Timeout: use a stub core holding `core_busy_i` = 1 with `TIMEOUT` = 20 -> status 01, 16 zero bytes, `cyc_cnt` 0x0014.
- Reset: assert `rst_n` low after byte 40 of a frame, then send a fresh full frame -> no load pulse from the aborted frame and a correct response for the new frame.
- Pass-through: use a stub core with header 0x20 and key bytes 0x01…0x20 -> `core_size_o` = 2 and `core_key_o` = 0x0102…1f20 during the load pulse.
